// File: rtl/round_robin_arbiter_8.sv
// rtl/round_robin_arbiter_8.sv - 8-way round-robin arbiter, registered one-hot + index grant
// Optional forced release after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module round_robin_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       force_rel;
  logic       release_now;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  // The owner is forced off once it has held the grant for MAX_HOLD cycles.
  assign force_rel = (state_q == GRANT) && req[idx_q] && (hold_q == 8'(MAX_HOLD - 1));

  // Count consecutive grant cycles; zero whenever the grant is not continuing.
  always_comb begin
    hold_d = 8'd0;
    if (state_q == GRANT && state_d == GRANT) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
  assign force_rel       = 1'b0;
`endif

  assign release_now = (state_q == GRANT) && (!req[idx_q] || force_rel);

  // Scan requests starting at the pointer, wrapping 7->0; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      gnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state: grant any request from IDLE, return to IDLE on every release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the pointer.
  always_comb begin
    gnt_d     = 8'd0;
    idx_d     = 3'd0;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d = 8'd1 << win_idx;
          idx_d = win_idx;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = idx_q + 3'd1;
          timeout_d = force_rel;
        end else begin
          gnt_d = gnt_q;
          idx_d = idx_q;
        end
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// tb/tb_round_robin_arbiter_8.sv - directed self-checking bench for round_robin_arbiter_8
module tb_round_robin_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp;
  int n_bad;

  round_robin_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    n_cmp++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: gnt=%h idx=%0d valid=%b to=%b, want 00/0/0/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    rst_n = 1'b1;
    req   = 8'h20;
    tick();
    n_cmp++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      n_bad++;
      $display("FAIL reset_pre_owner5: gnt=%h idx=%0d, want 20/5", gnt, gnt_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: gnt=%h idx=%0d valid=%b, want 00/0/0", gnt, gnt_idx, gnt_valid);
    end
    tick();
    req   = 8'hFF;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
      n_bad++;
      $display("FAIL reset_ptr_zero: gnt=%h idx=%0d, want 01/0", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h08;
    tick();
    n_cmp++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: gnt=%h idx=%0d valid=%b, want 08/3/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_release: gnt=%h idx=%0d valid=%b, want 00/0/0", gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'h01 << (k % 8);
      tick();
      n_cmp++;
      if (gnt_idx !== 3'(k % 8) || gnt !== exp_gnt || gnt_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rotation_grant[%0d]: gnt=%h idx=%0d, want %h/%0d", k, gnt, gnt_idx, exp_gnt, k % 8);
      end
      tick();
      n_cmp++;
      if (gnt !== exp_gnt) begin
        n_bad++;
        $display("FAIL rotation_hold[%0d]: gnt=%h, want %h", k, gnt, exp_gnt);
      end
      req = 8'hFF & ~exp_gnt;
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b0 || gnt !== 8'h00) begin
        n_bad++;
        $display("FAIL rotation_bubble[%0d]: gnt=%h valid=%b, want 00/0", k, gnt, gnt_valid);
      end
      req = 8'hFF;
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h20;
    tick();
    req = 8'h00;
    tick();
    req = 8'h21;
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
      n_bad++;
      $display("FAIL wrap_winner0: gnt=%h idx=%0d, want 01/0", gnt, gnt_idx);
    end
    req = 8'h20;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_bubble: valid=%b, want 0", gnt_valid);
    end
    req = 8'h21;
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin
      n_bad++;
      $display("FAIL wrap_winner5: gnt=%h idx=%0d, want 20/5", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 8'h04;
    tick();
    req = 8'h0C;
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd2 || gnt !== 8'h04) begin
      n_bad++;
      $display("FAIL sim_no_preempt: gnt=%h idx=%0d, want 04/2", gnt, gnt_idx);
    end
    req = 8'h04;
    tick();
    req = 8'h10;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00) begin
      n_bad++;
      $display("FAIL sim_bubble: gnt=%h valid=%b, want 00/0", gnt, gnt_valid);
    end
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd4 || gnt !== 8'h10) begin
      n_bad++;
      $display("FAIL sim_new_owner: gnt=%h idx=%0d, want 10/4", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    req = 8'h81;
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
      n_bad++;
      $display("FAIL hold_first: gnt=%h idx=%0d, want 01/0", gnt, gnt_idx);
    end
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_cycle[%0d]: gnt=%h to=%b, want 01/0", c, gnt, timeout);
      end
    end
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_timeout: valid=%b to=%b, want 0/1", gnt_valid, timeout);
    end
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd7 || gnt !== 8'h80 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_next_owner: gnt=%h idx=%0d to=%b, want 80/7/0", gnt, gnt_idx, timeout);
    end
`else
    for (int c = 2; c <= 21; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h01 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_forever[%0d]: gnt=%h idx=%0d to=%b, want 01/0/0", c, gnt, gnt_idx, timeout);
      end
    end
`endif
    req = 8'h00;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_simultaneous();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
